// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package regfile_ctrl_pkg;

    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_DATA_W   = 32;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a contested grant goes to the side not granted last.
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic       valid_a_i,
    input  logic       valid_b_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o      // [0] = A, [1] = B
);

    always_comb begin
        grant_o = '0;
        if (valid_a_i && valid_b_i) begin
            if (last_grant_i == GRANT_B) grant_o[0] = 1'b1;
            else                         grant_o[1] = 1'b1;
        end else if (valid_a_i) begin
            grant_o[0] = 1'b1;
        end else if (valid_b_i) begin
            grant_o[1] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port sequencer: zero sweep after reset, then round-robin
// sharing of the port between ALU (A) and load (B) writeback, r0 writes dropped.
module regfile_write_ctrl #(
    parameter int NUM_REGS = regfile_ctrl_pkg::DEFAULT_NUM_REGS,
    parameter int ADDR_W   = regfile_ctrl_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W   = regfile_ctrl_pkg::DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              init_done
);
    import regfile_ctrl_pkg::*;

    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              init_done_q, init_done_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        grant;

    // Requests only compete once the last sweep write has left the output register.
    rr_arbiter2 u_arb (
        .valid_a_i    (a_valid && init_done_q),
        .valid_b_i    (b_valid && init_done_q),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign a_ready       = grant[0];
    assign b_ready       = grant[1];
    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign init_done     = init_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        init_done_d  = init_done_q;
        regwrite_d   = 1'b0;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;

        case (state_q)
            INIT: begin
                regwrite_d = 1'b1;
                wreg_d     = ADDR_W'(cnt_q);
                wdata_d    = '0;
                if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                init_done_d = 1'b1;
                if (grant[0]) begin
                    last_grant_d = GRANT_A;
                    regwrite_d   = (a_addr != '0);
                    wreg_d       = a_addr;
                    wdata_d      = a_data;
                end else if (grant[1]) begin
                    last_grant_d = GRANT_B;
                    regwrite_d   = (b_addr != '0);
                    wreg_d       = b_addr;
                    wdata_d      = b_data;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            last_grant_q <= GRANT_B;
            init_done_q  <= 1'b0;
            regwrite_q   <= 1'b0;
            wreg_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            init_done_q  <= init_done_d;
            regwrite_q   <= regwrite_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: stimulus pushes expected writes, a monitor pops them.
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        init_done;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    logic [31:0] shadow [32];
    int          n_vec  = 0;
    int          n_fail = 0;

    regfile_write_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid       (a_valid),
        .a_addr        (a_addr),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        sb_q.push_back(w);
    endtask

    task automatic push_sweep();
        for (int unsigned r = 0; r < 32; r++) push(5'(r), 32'h0);
    endtask

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && RegWrite === 1'b1) begin
            wr_t w;
            shadow[WriteRegister] = WriteData;
            check("write_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                w = sb_q.pop_front();
                check("write_addr", 64'(WriteRegister), 64'(w.addr));
                check("write_data", 64'(WriteData), 64'(w.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned r = 0; r < 32; r++) shadow[r] = 32'hFFFF_FFFF;
        rst = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_regwrite",  64'(RegWrite), 64'd0);
        check("rst_wreg",      64'(WriteRegister), 64'd0);
        check("rst_wdata",     64'(WriteData), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);

        // Sweep aborted by reset once register 10 has been presented.
        push_sweep();
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 100 && sb_q.size() != 21; i++) begin
            @(negedge clk); #1;
        end
        check("abort_point", 64'(sb_q.size()), 64'd21);
        #1 rst = 1'b0;
        #1;
        check("abort_regwrite",  64'(RegWrite), 64'd0);
        check("abort_wreg",      64'(WriteRegister), 64'd0);
        check("abort_wdata",     64'(WriteData), 64'd0);
        check("abort_init_done", 64'(init_done), 64'd0);
        sb_q.delete();

        // Full sweep with both requesters pending on r7; A must win the first contest.
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h22;
        push_sweep();
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            @(negedge clk); #1;
            check("sweep_a_ready",   64'(a_ready), 64'd0);
            check("sweep_b_ready",   64'(b_ready), 64'd0);
            check("sweep_init_done", 64'(init_done), 64'd0);
        end
        check("sweep_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk); #1;
        check("post_init_done", 64'(init_done), 64'd1);
        check("first_a_ready",  64'(a_ready), 64'd1);
        check("first_b_ready",  64'(b_ready), 64'd0);
        push(5'd7, 32'h11);
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk); #1;
        check("second_a_ready", 64'(a_ready), 64'd0);
        check("second_b_ready", 64'(b_ready), 64'd1);
        push(5'd7, 32'h22);
        @(posedge clk); #1 b_valid = 1'b0;
        @(negedge clk); #1;
        check("r7_drained", 64'(sb_q.size()), 64'd0);
        check("r7_final",   64'(shadow[7]), 64'h22);

        // A only: accepted in N, written in N+1.
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        check("aonly_a_ready", 64'(a_ready), 64'd1);
        check("aonly_b_ready", 64'(b_ready), 64'd0);
        push(5'd5, 32'hDEAD_BEEF);
        @(posedge clk); #1 a_valid = 1'b0;
        @(negedge clk); #1;
        check("aonly_latency", 64'(sb_q.size()), 64'd0);
        check("r5_value",      64'(shadow[5]), 64'hDEAD_BEEF);

        // Continuous contention: A was granted last, so B leads and they alternate.
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB0;
        for (int i = 0; i < 8; i++) begin
            logic exp_b;
            exp_b = (i % 2 == 0);
            @(negedge clk); #1;
            check("rr_a_ready", 64'(a_ready), 64'(!exp_b));
            check("rr_b_ready", 64'(b_ready), 64'(exp_b));
            if (exp_b) push(b_addr, b_data);
            else       push(a_addr, a_data);
            if (i > 0) check("rr_no_gap", 64'(sb_q.size()), 64'd1);
            @(posedge clk); #1;
            if (exp_b) b_data = b_data + 32'd1;
            else       a_data = a_data + 32'd1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk); #1;
        check("rr_drained", 64'(sb_q.size()), 64'd0);

        // B writes r0: consumed, but no write strobe follows.
        @(posedge clk); #1;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        @(negedge clk); #1;
        check("r0_b_ready", 64'(b_ready), 64'd1);
        @(posedge clk); #1 b_valid = 1'b0;
        @(negedge clk); #1;
        check("r0_suppressed", 64'(RegWrite), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        check("final_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
